// File: rtl/bsg_manycore_proc_fwd_out_buffer.sv
// Forward-channel output buffer between the tile endpoint and the router's
// local input port. It is a circular FIFO with an occupancy output, a
// high-water mark and a saturating counter of router-backpressure cycles.
module bsg_manycore_proc_fwd_out_buffer #(
    parameter int  packet_width_p = 32,
    parameter int  els_p          = 4,
    parameter int  stall_width_p  = 16,
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      proc_v_i,
    input  logic [packet_width_p-1:0] proc_packet_i,
    output logic                      proc_ready_o,

    output logic                      router_v_o,
    output logic [packet_width_p-1:0] router_packet_o,
    input  logic                      router_ready_i,

    input  logic                      clear_stats_i,
    output logic [count_width_lp-1:0] count_o,
    output logic [count_width_lp-1:0] hwm_o,
    output logic [stall_width_p-1:0]  stall_cnt_o
);

    localparam int                      ptr_width_lp = $clog2(els_p);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp  = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] full_cnt_lp = count_width_lp'(els_p);
    localparam logic [stall_width_p-1:0]  stall_max_lp = {stall_width_p{1'b1}};

    logic [packet_width_p-1:0] mem_q [els_p];

    logic [ptr_width_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_width_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [count_width_lp-1:0] count_q,  count_d;
    logic [count_width_lp-1:0] hwm_q,    hwm_d;
    logic [stall_width_p-1:0]  stall_q,  stall_d;

    logic enq;
    logic deq;
    logic stall_cycle;

    // Handshake flags come only from registered occupancy, so reset clears
    // them immediately and the upstream ready never depends on the router.
    assign proc_ready_o    = (count_q != full_cnt_lp);
    assign router_v_o      = (count_q != '0);
    assign router_packet_o = mem_q[rd_ptr_q];
    assign count_o         = count_q;
    assign hwm_o           = hwm_q;
    assign stall_cnt_o     = stall_q;

    assign enq         = proc_v_i & proc_ready_o;
    assign deq         = router_v_o & router_ready_i;
    assign stall_cycle = router_v_o & ~router_ready_i;

    // Next-state for pointers, occupancy and statistics.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hwm_d    = hwm_q;
        stall_d  = stall_q;

        // Explicit wrap so depths that are not powers of two work.
        if (enq) begin
            wr_ptr_d = (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + ptr_width_lp'(1);
        end
        if (deq) begin
            rd_ptr_d = (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + ptr_width_lp'(1);
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + count_width_lp'(1);
            2'b01:   count_d = count_q - count_width_lp'(1);
            default: count_d = count_q;
        endcase

        // The high-water mark tracks the post-update occupancy; a clear
        // restarts it from that same value rather than from zero.
        if (clear_stats_i) begin
            hwm_d   = count_d;
            stall_d = '0;
        end else begin
            if (count_d > hwm_q) begin
                hwm_d = count_d;
            end
            if (stall_cycle && (stall_q != stall_max_lp)) begin
                stall_d = stall_q + stall_width_p'(1);
            end
        end
    end

    // Control and statistics registers; reset discards buffered packets.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hwm_q    <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hwm_q    <= hwm_d;
            stall_q  <= stall_d;
        end
    end

    // Packet storage; written only on an accepted enqueue so X data on an
    // idle input never reaches the array.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; router_v_o masks stale contents, and a reset here would cost a mux per bit.
        if (enq) begin
            mem_q[wr_ptr_q] <= proc_packet_i;
        end
    end

`ifndef SYNTHESIS
    a_no_enq_when_full: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        enq |-> (count_q != full_cnt_lp));
    a_count_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        count_q <= full_cnt_lp);
    a_ptrs_in_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (wr_ptr_q <= last_ptr_lp) && (rd_ptr_q <= last_ptr_lp));
`endif

endmodule
